// File: rtl/imem_arb_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM encodings,
// port-select constants and the default ROM base address.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic SEL_F = 1'b0;
  localparam logic SEL_D = 1'b1;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0040_0000;

endpackage

// File: rtl/imem_addr_check.sv
// Combinational fault detector for ROM byte addresses: below base,
// misaligned, or word index beyond the ROM depth.
module imem_addr_check #(
  parameter int DATA_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 64
) (
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] base_addr,
  output logic                  fault
);

  localparam logic [DATA_WIDTH-1:0] DEPTH = DATA_WIDTH'(MEMORY_DEPTH);

  logic [DATA_WIDTH-1:0] index_s;

  // The subtraction only happens once addr >= base_addr, so it cannot wrap.
  always_comb begin
    index_s = {DATA_WIDTH{1'b0}};
    fault   = 1'b0;
    if (addr < base_addr) begin
      fault = 1'b1;
    end else begin
      index_s = (addr - base_addr) >> 2'd2;
      if (addr[1:0] != 2'b00) begin
        fault = 1'b1;
      end else if (index_s >= DEPTH) begin
        fault = 1'b1;
      end else begin
        fault = 1'b0;
      end
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port (fetch / debug) arbiter and sequencer for the asynchronous program ROM.
// Define IMEM_ARB_RR_EN for round-robin tie breaking; otherwise fetch has fixed priority.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = DATA_WIDTH'(DEFAULT_BASE_ADDR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req_i,
  input  logic [DATA_WIDTH-1:0] f_addr_i,
  output logic                  f_gnt_o,
  output logic                  f_rvalid_o,
  output logic [DATA_WIDTH-1:0] f_rdata_o,
  output logic                  f_err_o,
  input  logic                  d_req_i,
  input  logic [DATA_WIDTH-1:0] d_addr_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  d_err_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  state_t                state_r, state_nxt;
  logic                  sel_r, sel_nxt, pick_s;
  logic                  fault_r, fault_nxt, fault_s;
  logic                  any_req_s;
  logic [DATA_WIDTH-1:0] win_addr_s;

  logic                  f_gnt_r, f_gnt_nxt, d_gnt_r, d_gnt_nxt;
  logic                  f_rvalid_r, f_rvalid_nxt, d_rvalid_r, d_rvalid_nxt;
  logic                  f_err_r, f_err_nxt, d_err_r, d_err_nxt;
  logic [DATA_WIDTH-1:0] f_rdata_r, f_rdata_nxt, d_rdata_r, d_rdata_nxt;
  logic [DATA_WIDTH-1:0] mem_addr_r, mem_addr_nxt;

`ifdef IMEM_ARB_RR_EN
  logic prio_r;

  // Tie-break pointer: the port granted last loses the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_r <= SEL_F;
    end else if (state_r == BUSY) begin
      prio_r <= ~sel_r;
    end else begin
      prio_r <= prio_r;
    end
  end
`endif

  // Winner selection and its address, evaluated whenever requests may be sampled.
  always_comb begin
    pick_s     = SEL_F;
    win_addr_s = f_addr_i;
    any_req_s  = f_req_i | d_req_i;
`ifdef IMEM_ARB_RR_EN
    if (f_req_i && d_req_i) begin
      pick_s = prio_r;
    end else if (f_req_i) begin
      pick_s = SEL_F;
    end else begin
      pick_s = SEL_D;
    end
`else
    if (f_req_i) begin
      pick_s = SEL_F;
    end else begin
      pick_s = SEL_D;
    end
`endif
    if (pick_s == SEL_D) begin
      win_addr_s = d_addr_i;
    end else begin
      win_addr_s = f_addr_i;
    end
  end

  // The fault is judged on exactly the address being latched for the access.
  imem_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH)
  ) u_addr_check (
    .addr     (win_addr_s),
    .base_addr(BASE_ADDR),
    .fault    (fault_s)
  );

  // State register together with the latched winner and its fault flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      sel_r   <= SEL_F;
      fault_r <= 1'b0;
    end else begin
      state_r <= state_nxt;
      sel_r   <= sel_nxt;
      fault_r <= fault_nxt;
    end
  end

  // Next-state logic: requests are only sampled in IDLE and RESP.
  always_comb begin
    state_nxt = state_r;
    sel_nxt   = sel_r;
    fault_nxt = fault_r;
    case (state_r)
      IDLE, RESP: begin
        if (any_req_s) begin
          state_nxt = BUSY;
          sel_nxt   = pick_s;
          fault_nxt = fault_s;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY:    state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered port outputs.
  always_comb begin
    f_gnt_nxt    = (state_nxt == BUSY) && (sel_nxt == SEL_F);
    d_gnt_nxt    = (state_nxt == BUSY) && (sel_nxt == SEL_D);
    f_rvalid_nxt = (state_r == BUSY) && (sel_r == SEL_F);
    d_rvalid_nxt = (state_r == BUSY) && (sel_r == SEL_D);
    f_err_nxt    = f_rvalid_nxt && fault_r;
    d_err_nxt    = d_rvalid_nxt && fault_r;
    f_rdata_nxt  = f_rdata_r;
    d_rdata_nxt  = d_rdata_r;
    mem_addr_nxt = BASE_ADDR;
    if (f_rvalid_nxt) begin
      f_rdata_nxt = fault_r ? {DATA_WIDTH{1'b0}} : mem_data_i;
    end else begin
      f_rdata_nxt = f_rdata_r;
    end
    if (d_rvalid_nxt) begin
      d_rdata_nxt = fault_r ? {DATA_WIDTH{1'b0}} : mem_data_i;
    end else begin
      d_rdata_nxt = d_rdata_r;
    end
    // A faulting access never presents its address to the ROM.
    if ((state_nxt == BUSY) && !fault_nxt) begin
      mem_addr_nxt = win_addr_s;
    end else begin
      mem_addr_nxt = BASE_ADDR;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_gnt_r    <= 1'b0;
      d_gnt_r    <= 1'b0;
      f_rvalid_r <= 1'b0;
      d_rvalid_r <= 1'b0;
      f_err_r    <= 1'b0;
      d_err_r    <= 1'b0;
      f_rdata_r  <= {DATA_WIDTH{1'b0}};
      d_rdata_r  <= {DATA_WIDTH{1'b0}};
      mem_addr_r <= BASE_ADDR;
    end else begin
      f_gnt_r    <= f_gnt_nxt;
      d_gnt_r    <= d_gnt_nxt;
      f_rvalid_r <= f_rvalid_nxt;
      d_rvalid_r <= d_rvalid_nxt;
      f_err_r    <= f_err_nxt;
      d_err_r    <= d_err_nxt;
      f_rdata_r  <= f_rdata_nxt;
      d_rdata_r  <= d_rdata_nxt;
      mem_addr_r <= mem_addr_nxt;
    end
  end

  assign f_gnt_o    = f_gnt_r;
  assign d_gnt_o    = d_gnt_r;
  assign f_rvalid_o = f_rvalid_r;
  assign d_rvalid_o = d_rvalid_r;
  assign f_err_o    = f_err_r;
  assign d_err_o    = d_err_r;
  assign f_rdata_o  = f_rdata_r;
  assign d_rdata_o  = d_rdata_r;
  assign mem_addr_o = mem_addr_r;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level model of the arbitration rules.
module tb_imem_arbiter;

  localparam logic [31:0] BASE = 32'h0040_0000;
`ifdef IMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req, d_req;
  logic [31:0] f_addr, d_addr;
  logic        f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_data;
  logic [31:0] rom [0:63];
  logic [31:0] rom_off;

  int tests_run = 0;
  int tests_failed = 0;

  imem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req_i(f_req), .f_addr_i(f_addr), .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid),
    .f_rdata_o(f_rdata), .f_err_o(f_err),
    .d_req_i(d_req), .d_addr_i(d_addr), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
    .d_rdata_o(d_rdata), .d_err_o(d_err),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data)
  );

  always #5 clk = ~clk;

  // Asynchronous ROM; out-of-window addresses return a poison word.
  always_comb begin
    rom_off  = mem_addr - BASE;
    mem_data = 32'hDEAD_BEEF;
    if (mem_addr >= BASE && rom_off < 32'd256 && mem_addr[1:0] == 2'b00)
      mem_data = rom[rom_off[7:2]];
  end

  function automatic logic model_fault(input logic [31:0] a);
    if (a < BASE) return 1'b1;
    if (a % 32'd4 != 32'd0) return 1'b1;
    return ((a - BASE) / 32'd4) >= 32'd64;
  endfunction

  function automatic logic [31:0] model_data(input logic [31:0] a);
    int idx;
    if (model_fault(a)) return 32'h0;
    idx = int'((a - BASE) / 32'd4);
    return rom[idx];
  endfunction

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      0: return BASE - 32'd4 * $urandom_range(1, 16);
      1: return BASE + 32'd4 * $urandom_range(0, 63) + $urandom_range(1, 3);
      2: return BASE + 32'd256 + 32'd4 * $urandom_range(0, 63);
      3: return $urandom;
      default: return BASE + 32'd4 * $urandom_range(0, 63);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0; f_addr = BASE; d_addr = BASE;
    step(); step();
    tests_run++;
    if ({f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000000", {f_gnt, d_gnt, f_rvalid, d_rvalid, f_err, d_err});
    end
    tests_run++;
    if (f_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_rdata: got %h/%h want 0/0", f_rdata, d_rdata);
    end
    tests_run++;
    if (mem_addr !== BASE) begin
      tests_failed++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, BASE);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_fetch_basic();
    f_req = 1'b1; f_addr = 32'h0040_0008;
    step();
    tests_run++;
    if ({f_gnt, d_gnt, f_rvalid} !== 3'b100 || mem_addr !== 32'h0040_0008) begin
      tests_failed++; $display("FAIL basic_gnt: got gnt=%b%b rv=%b addr=%h want 10 0 00400008", f_gnt, d_gnt, f_rvalid, mem_addr);
    end
    f_req = 1'b0;
    step();
    tests_run++;
    if ({f_gnt, f_rvalid, f_err} !== 3'b010 || f_rdata !== 32'h2008_0005) begin
      tests_failed++; $display("FAIL basic_resp: got g/rv/err=%b data=%h want 010 20080005", {f_gnt, f_rvalid, f_err}, f_rdata);
    end
    step();
  endtask

  task automatic test_simultaneous();
    logic exp_d;
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0;
    step();
    reset = 1'b0; f_req = 1'b1; d_req = 1'b1; f_addr = BASE + 32'd12; d_addr = BASE + 32'd28;
    step();
    tests_run++;
    if ({f_gnt, d_gnt} !== 2'b10) begin
      tests_failed++; $display("FAIL tie_first: got %b%b want 10", f_gnt, d_gnt);
    end
    f_req = 1'b0;
    step();
    tests_run++;
    if (f_rvalid !== 1'b1 || d_gnt !== 1'b0 || f_rdata !== rom[3]) begin
      tests_failed++; $display("FAIL tie_f_resp: got rv=%b dg=%b data=%h want 1 0 %h", f_rvalid, d_gnt, f_rdata, rom[3]);
    end
    step();
    tests_run++;
    if (d_gnt !== 1'b1 || mem_addr !== BASE + 32'd28) begin
      tests_failed++; $display("FAIL tie_d_gnt: got g=%b addr=%h want 1 %h", d_gnt, mem_addr, BASE + 32'd28);
    end
    d_req = 1'b0;
    step();
    tests_run++;
    if (d_rvalid !== 1'b1 || d_rdata !== rom[7] || f_rvalid !== 1'b0) begin
      tests_failed++; $display("FAIL tie_d_resp: got rv=%b data=%h want 1 %h", d_rvalid, d_rdata, rom[7]);
    end
    // Repeated ties: RR alternates starting with fetch, fixed priority always picks fetch.
    f_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_d = RR && (i % 2 == 1);
      step();
      tests_run++;
      if ({f_gnt, d_gnt} !== {!exp_d, exp_d}) begin
        tests_failed++; $display("FAIL tie_seq_gnt%0d: got %b%b want %b%b", i, f_gnt, d_gnt, !exp_d, exp_d);
      end
      step();
      tests_run++;
      if ({f_rvalid, d_rvalid} !== {!exp_d, exp_d}) begin
        tests_failed++; $display("FAIL tie_seq_rv%0d: got %b%b want %b%b", i, f_rvalid, d_rvalid, !exp_d, exp_d);
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    step();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [31:0] f_keep;
    addrs[0] = 32'h0040_0100; addrs[1] = 32'h0040_0002; addrs[2] = 32'h003F_FFFC;
    f_keep = f_rdata;
    for (int i = 0; i < 3; i++) begin
      d_req = 1'b1; d_addr = addrs[i];
      step();
      tests_run++;
      if (d_gnt !== 1'b1 || mem_addr !== BASE) begin
        tests_failed++; $display("FAIL fault%0d_gnt: got g=%b addr=%h want 1 %h", i, d_gnt, mem_addr, BASE);
      end
      d_req = 1'b0;
      step();
      tests_run++;
      if ({d_rvalid, d_err, f_rvalid, f_err} !== 4'b1100 || d_rdata !== 32'h0 || f_rdata !== f_keep) begin
        tests_failed++; $display("FAIL fault%0d_resp: got rv/err/frv/ferr=%b d=%h f=%h want 1100 0 %h",
                                 i, {d_rvalid, d_err, f_rvalid, f_err}, d_rdata, f_rdata, f_keep);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    f_req = 1'b1; f_addr = BASE + 32'd40;
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if (f_gnt !== 1'b1 || f_rvalid !== 1'b0 || mem_addr !== BASE + 32'd4 * (10 + i)) begin
        tests_failed++; $display("FAIL b2b_gnt%0d: got g=%b rv=%b addr=%h", i, f_gnt, f_rvalid, mem_addr);
      end
      step();
      tests_run++;
      if (f_gnt !== 1'b0 || f_rvalid !== 1'b1 || f_rdata !== rom[10 + i]) begin
        tests_failed++; $display("FAIL b2b_resp%0d: got g=%b rv=%b data=%h want 0 1 %h", i, f_gnt, f_rvalid, f_rdata, rom[10 + i]);
      end
      if (i < 3) f_addr = BASE + 32'd4 * (11 + i);
      else f_req = 1'b0;
    end
    step(); step();
    tests_run++;
    if (f_rvalid !== 1'b0 || f_gnt !== 1'b0 || f_rdata !== rom[13]) begin
      tests_failed++; $display("FAIL b2b_hold: got rv=%b g=%b data=%h want 0 0 %h", f_rvalid, f_gnt, f_rdata, rom[13]);
    end
  endtask

  task automatic test_reset_in_busy();
    f_req = 1'b1; f_addr = BASE + 32'd20;
    step();
    tests_run++;
    if (f_gnt !== 1'b1) begin
      tests_failed++; $display("FAIL rst_busy_gnt: got %b want 1", f_gnt);
    end
    reset = 1'b1; f_req = 1'b0;
    step();
    tests_run++;
    if ({f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err} !== 6'b0 || f_rdata !== 32'h0 || mem_addr !== BASE) begin
      tests_failed++; $display("FAIL rst_busy_clear: got flags=%b data=%h addr=%h",
                               {f_gnt, f_rvalid, f_err, d_gnt, d_rvalid, d_err}, f_rdata, mem_addr);
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      tests_run++;
      if (f_rvalid !== 1'b0 || f_gnt !== 1'b0) begin
        tests_failed++; $display("FAIL rst_busy_norv%0d: got rv=%b g=%b want 0 0", i, f_rvalid, f_gnt);
      end
    end
  endtask

  task automatic test_last_word();
    f_req = 1'b1; f_addr = 32'h0040_00FC;
    step();
    f_req = 1'b0;
    step();
    tests_run++;
    if (f_rvalid !== 1'b1 || f_err !== 1'b0 || f_rdata !== rom[63]) begin
      tests_failed++; $display("FAIL last_word: got rv=%b err=%b data=%h want 1 0 %h", f_rvalid, f_err, f_rdata, rom[63]);
    end
    step();
  endtask

  // Random traffic: the model knows the arbiter is free from the cycle after
  // each grant onward, and that a grant is followed one cycle later by its response.
  task automatic test_random();
    bit pg, pg_d, pr, pr_d, pr_err, f_prev_g, d_prev_g, last_d, win_d;
    logic [31:0] pg_addr, pr_data, f_hold, d_hold, exp_addr;
    int last_gnt;
    reset = 1'b1; f_req = 1'b0; d_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    pg = 1'b0; pg_d = 1'b0; pr = 1'b0; pr_d = 1'b0; f_prev_g = 1'b0; d_prev_g = 1'b0;
    last_d = 1'b1; last_gnt = -10; f_hold = 32'h0; d_hold = 32'h0; pg_addr = BASE;
    for (int k = 0; k < 600; k++) begin
      step();
      if (pr) begin
        if (pr_d) d_hold = pr_data;
        else f_hold = pr_data;
      end
      tests_run++;
      if ({f_gnt, d_gnt} !== {pg && !pg_d, pg && pg_d}) begin
        tests_failed++; $display("FAIL rnd_gnt@%0d: got %b%b want %b%b", k, f_gnt, d_gnt, pg && !pg_d, pg && pg_d);
      end
      tests_run++;
      if ({f_rvalid, d_rvalid, f_err, d_err} !== {pr && !pr_d, pr && pr_d, pr && !pr_d && pr_err, pr && pr_d && pr_err}) begin
        tests_failed++; $display("FAIL rnd_rv@%0d: got %b want %b", k, {f_rvalid, d_rvalid, f_err, d_err},
                                 {pr && !pr_d, pr && pr_d, pr && !pr_d && pr_err, pr && pr_d && pr_err});
      end
      tests_run++;
      if (f_rdata !== f_hold || d_rdata !== d_hold) begin
        tests_failed++; $display("FAIL rnd_rdata@%0d: got %h/%h want %h/%h", k, f_rdata, d_rdata, f_hold, d_hold);
      end
      if (pg) begin
        exp_addr = model_fault(pg_addr) ? BASE : pg_addr;
        tests_run++;
        if (mem_addr !== exp_addr) begin
          tests_failed++; $display("FAIL rnd_mem_addr@%0d: got %h want %h", k, mem_addr, exp_addr);
        end
      end
      pr = pg; pr_d = pg_d; pr_err = model_fault(pg_addr); pr_data = model_data(pg_addr);
      if (f_prev_g) begin
        f_req = 1'($urandom_range(0, 1));
        if (f_req) f_addr = rand_addr();
      end else if (!f_req && $urandom_range(0, 2) == 0) begin
        f_req = 1'b1; f_addr = rand_addr();
      end
      if (d_prev_g) begin
        d_req = 1'($urandom_range(0, 1));
        if (d_req) d_addr = rand_addr();
      end else if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_addr = rand_addr();
      end
      f_prev_g = pg && !pg_d;
      d_prev_g = pg && pg_d;
      if ((k >= last_gnt + 1) && (f_req || d_req)) begin
        if (f_req && d_req) win_d = RR ? !last_d : 1'b0;
        else win_d = d_req;
        pg = 1'b1; pg_d = win_d; pg_addr = win_d ? d_addr : f_addr;
        last_d = win_d; last_gnt = k + 1;
      end else begin
        pg = 1'b0;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    step(); step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[2] = 32'h2008_0005;
    test_reset();
    test_fetch_basic();
    test_simultaneous();
    test_faults();
    test_back_to_back();
    test_reset_in_busy();
    test_last_word();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
